matb_loader: RTL and testbench

Upstream feeder for the B-matrix skew stage. Accepts one DIM-element row of B per handshake into a DIM×DIM register buffer. On `start`, streams the rows in order on `b_row` with `fifo_en` asserted, then drives zero rows for `FLUSH_CYCLES` more cycles so the deepest skew FIFO drains completely into the systolic array. `done` pulses on completion and the block re-arms for the next matrix.

---
 rtl/matb_loader.sv | 119 +++++++++++
 tb/tb_matb_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matb_loader.sv
// B-matrix feeder: buffers DIM rows of B via a valid/ready write port, then on
// start streams them to the skew stage followed by zero rows that drain its FIFOs.
module matb_loader #(
  parameter int BITS_AB      = 8,
  parameter int DIM          = 8,
  parameter int FLUSH_CYCLES = 2 * DIM - 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic signed [DIM-1:0][BITS_AB-1:0] wr_row,
  input  logic                              start,
  output logic signed [DIM-1:0][BITS_AB-1:0] b_row,
  output logic                              fifo_en,
  output logic                              busy,
  output logic                              done
);

  localparam int WCW = $clog2(DIM + 1);
  localparam int RCW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [WCW-1:0] WR_LAST = WCW'(DIM - 1);
  localparam logic [RCW-1:0] RD_LAST = RCW'(DIM - 1);
  localparam logic [FCW-1:0] FL_LAST = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_FULL,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  typedef logic [DIM-1:0][BITS_AB-1:0] row_t;

  state_t         state, state_d;
  logic [WCW-1:0] wr_cnt, wr_cnt_d;
  logic [RCW-1:0] rd_cnt, rd_cnt_d;
  logic [FCW-1:0] fl_cnt, fl_cnt_d;
  row_t           row_buf [DIM];
  logic           wr_accept;

  assign wr_accept = (state == S_LOAD) && wr_valid;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_LOAD;
      wr_cnt <= '0;
      rd_cnt <= '0;
      fl_cnt <= '0;
    end else begin
      state  <= state_d;
      wr_cnt <= wr_cnt_d;
      rd_cnt <= rd_cnt_d;
      fl_cnt <= fl_cnt_d;
    end
  end

  // NOTE: the row buffer has no reset; b_row masks it to zero outside STREAM.
  // Writes are still gated by rst_n so a row presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr_accept) begin
      row_buf[wr_cnt[RCW-1:0]] <= wr_row;
    end
  end

  // NOTE: every signal driven here gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state;
    wr_cnt_d = wr_cnt;
    rd_cnt_d = rd_cnt;
    fl_cnt_d = fl_cnt;
    unique case (state)
      S_LOAD: begin
        if (wr_valid) begin
          wr_cnt_d = wr_cnt + WCW'(1);
          if (wr_cnt == WR_LAST) state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (start) begin
          state_d  = S_STREAM;
          rd_cnt_d = '0;
        end
      end
      S_STREAM: begin
        if (rd_cnt == RD_LAST) begin
          state_d  = S_FLUSH;
          fl_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt + RCW'(1);
        end
      end
      S_FLUSH: begin
        if (fl_cnt == FL_LAST) state_d = S_DONE;
        else                   fl_cnt_d = fl_cnt + FCW'(1);
      end
      S_DONE: begin
        state_d  = S_LOAD;
        wr_cnt_d = '0;
      end
      default: begin
        state_d  = S_LOAD;
        wr_cnt_d = '0;
      end
    endcase
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign wr_ready = (state == S_LOAD);
  assign fifo_en  = (state == S_STREAM) || (state == S_FLUSH);
  assign busy     = fifo_en;
  assign done     = (state == S_DONE);
  assign b_row    = (state == S_STREAM) ? row_buf[rd_cnt] : '0;

endmodule

// File: tb/tb_matb_loader.sv
// Self-checking bench for matb_loader: a row-array model plus the documented
// cycle schedule supplies every expected value.
module tb_matb_loader;

  localparam int BITS_AB = 8;
  localparam int DIM     = 8;
  localparam int FLUSH   = 2 * DIM - 1;

  typedef logic [DIM-1:0][BITS_AB-1:0] row_t;

  logic clk = 1'b0;
  logic rst_n, wr_valid, start;
  logic wr_ready, fifo_en, busy, done;
  row_t wr_row, b_row;

  int n_tests = 0;
  int n_fail  = 0;

  row_t model_buf [DIM];
  row_t next_mat  [DIM];

  matb_loader #(
    .BITS_AB     (BITS_AB),
    .DIM         (DIM),
    .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_row  (wr_row),
    .start   (start),
    .b_row   (b_row),
    .fifo_en (fifo_en),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic row_t rand_row();
    row_t r;
    for (int j = 0; j < DIM; j++) r[j] = BITS_AB'($urandom);
    return r;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < DIM; i++) next_mat[i] = rand_row();
  endtask

  // bubble_mode: 0 none, 1 alternate valid/idle, 2 random gaps
  task automatic load_matrix(input string tag, input int bubble_mode, input bit start_during);
    int gaps;
    for (int i = 0; i < DIM; i++) begin
      if (bubble_mode == 1)      gaps = (i > 0) ? 1 : 0;
      else if (bubble_mode == 2) gaps = int'($urandom_range(0, 2));
      else                       gaps = 0;
      repeat (gaps) begin
        wr_valid = 1'b0;
        wr_row   = rand_row();
        start    = start_during;
        step();
      end
      wr_valid = 1'b1;
      wr_row   = next_mat[i];
      start    = start_during;
      n_tests++;
      if ({wr_ready, fifo_en, busy, done} !== 4'b1000) begin
        n_fail++;
        $display("FAIL %s load row %0d ctl: got %b exp 1000", tag, i,
                 {wr_ready, fifo_en, busy, done});
      end
      step();
      model_buf[i] = next_mat[i];
    end
    wr_valid = 1'b0;
    start    = 1'b0;
    n_tests++;
    if ({wr_ready, fifo_en, busy, done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL %s after load ctl: got %b exp 0000", tag, {wr_ready, fifo_en, busy, done});
    end
  endtask

  // Pulses start in FULL and checks every cycle of the stream/flush/done schedule.
  // abort_at > 0 applies reset during that stream cycle and checks the abort.
  task automatic run_stream(input string tag, input int abort_at);
    int   dones;
    row_t exp_row;
    logic [3:0] exp_ctl;
    dones = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= DIM + FLUSH + 1; t++) begin
      exp_row = (t <= DIM) ? model_buf[t-1] : '0;
      exp_ctl = {1'b0, logic'(t <= DIM + FLUSH), logic'(t <= DIM + FLUSH),
                 logic'(t == DIM + FLUSH + 1)};
      n_tests++;
      if ({wr_ready, fifo_en, busy, done} !== exp_ctl) begin
        n_fail++;
        $display("FAIL %s ctl cycle %0d: got %b exp %b", tag, t,
                 {wr_ready, fifo_en, busy, done}, exp_ctl);
      end
      n_tests++;
      if (b_row !== exp_row) begin
        n_fail++;
        $display("FAIL %s b_row cycle %0d: got %h exp %h", tag, t, b_row, exp_row);
      end
      if (done === 1'b1) dones++;
      if (t == abort_at) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_tests++;
        if ({wr_ready, fifo_en, busy, done} !== 4'b1000 || b_row !== '0) begin
          n_fail++;
          $display("FAIL %s abort state: ctl %b b_row %h exp ctl 1000 b_row 0", tag,
                   {wr_ready, fifo_en, busy, done}, b_row);
        end
        repeat (DIM + FLUSH + 2) begin
          step();
          if (done === 1'b1 || fifo_en === 1'b1) dones++;
        end
        n_tests++;
        if (dones !== 0) begin
          n_fail++;
          $display("FAIL %s done/fifo_en after abort: got %0d exp 0", tag, dones);
        end
        return;
      end
      if (t <= DIM + FLUSH) step();
    end
    step();
    n_tests++;
    if ({wr_ready, fifo_en, busy, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL %s re-arm ctl: got %b exp 1000", tag, {wr_ready, fifo_en, busy, done});
    end
    n_tests++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL %s done count: got %0d exp 1", tag, dones);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    start    = 1'b1;
    wr_row   = rand_row();
    for (int c = 0; c < 2; c++) begin
      step();
      n_tests++;
      if ({wr_ready, fifo_en, busy, done} !== 4'b1000 || b_row !== '0) begin
        n_fail++;
        $display("FAIL reset cycle %0d: ctl %b b_row %h exp ctl 1000 b_row 0", c,
                 {wr_ready, fifo_en, busy, done}, b_row);
      end
    end
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic test_load_bubbles();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) next_mat[i][j] = BITS_AB'(8 * i + j - 32);
    load_matrix("bubbles", 1, 1'b0);
    // writes presented while FULL must be refused and leave the buffer intact
    for (int c = 0; c < 3; c++) begin
      wr_valid = 1'b1;
      wr_row   = rand_row();
      step();
      n_tests++;
      if ({wr_ready, fifo_en, busy, done} !== 4'b0000) begin
        n_fail++;
        $display("FAIL extra write %0d ctl: got %b exp 0000", c, {wr_ready, fifo_en, busy, done});
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_full_stream();
    run_stream("full", 0);
  endtask

  task automatic test_early_start();
    fill_random();
    load_matrix("early", 2, 1'b1);
    for (int c = 0; c < 3; c++) begin
      step();
      n_tests++;
      if ({wr_ready, fifo_en, busy, done} !== 4'b0000) begin
        n_fail++;
        $display("FAIL early idle %0d ctl: got %b exp 0000", c, {wr_ready, fifo_en, busy, done});
      end
    end
    run_stream("early", 0);
  endtask

  task automatic test_mid_reset();
    fill_random();
    load_matrix("abort_load", 0, 1'b0);
    run_stream("abort", DIM + 3);
    // partial load of junk, then reset: the next load must restart at row 0
    wr_valid = 1'b1;
    repeat (3) begin
      wr_row = rand_row();
      step();
    end
    wr_valid = 1'b0;
    rst_n    = 1'b0;
    step();
    rst_n = 1'b1;
    n_tests++;
    if ({wr_ready, fifo_en, busy, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL partial reset ctl: got %b exp 1000", {wr_ready, fifo_en, busy, done});
    end
    fill_random();
    load_matrix("reload", 2, 1'b0);
    run_stream("reload", 0);
  endtask

  task automatic test_back_to_back();
    fill_random();
    load_matrix("b2b_a", 0, 1'b0);
    run_stream("b2b_a", 0);
    fill_random();
    load_matrix("b2b_b", 0, 1'b0);
    run_stream("b2b_b", 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    start    = 1'b0;
    wr_row   = '0;
    test_reset();
    test_load_bubbles();
    test_full_stream();
    test_early_start();
    test_mid_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
